// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared widths, arbitration modes and grant FSM states for bus_arbiter
package bus_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  localparam logic [DATA_W-1:0] TIMEOUT_RDATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bus_arb_timeout.sv
// rtl/bus_arb_timeout.sv - stall counter that flags the cycle a granted transfer has waited MAX_CYCLES
module bus_arb_timeout #(
  parameter int unsigned MAX_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry lands on the stalled cycle that brings the wait count up to MAX_CYCLES.
  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master valid/ready bus arbiter, RR or fixed priority; BUS_ARB_TIMEOUT_EN adds the watchdog
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned       ARB_MODE       = ARB_RR,
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = TIMEOUT_RDATA_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        grant,
  output logic              bus_err,
  output logic [ADDR_W-1:0] err_addr
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;

  logic              owning, sel1, own_valid, own_rdy, tmo_expire;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata, own_rdata;
  logic [STRB_W-1:0] own_wstrb;

  assign owning    = (state_q == OWN0) || (state_q == OWN1);
  assign sel1      = (state_q == OWN1);
  assign own_valid = sel1 ? m1_valid : m0_valid;
  assign own_addr  = sel1 ? m1_addr  : m0_addr;
  assign own_wdata = sel1 ? m1_wdata : m0_wdata;
  assign own_wstrb = sel1 ? m1_wstrb : m0_wstrb;
  assign grant     = {state_q == OWN1, state_q == OWN0};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // last_q remembers the master served most recently; a dropped request leaves it alone.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          state_d = ((ARB_MODE == ARB_FIXED) || last_q) ? OWN0 : OWN1;
        end else if (m0_valid) begin
          state_d = OWN0;
        end else if (m1_valid) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (!own_valid) begin
          state_d = IDLE;
        end else if (s_ready || tmo_expire) begin
          state_d = IDLE;
          last_d  = sel1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_valid   = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    m0_ready  = 1'b0;
    m0_rdata  = '0;
    m1_ready  = 1'b0;
    m1_rdata  = '0;
    own_rdy   = 1'b0;
    own_rdata = '0;
    if (owning) begin
      s_valid   = own_valid && !tmo_expire;
      s_addr    = own_addr;
      s_wdata   = own_wdata;
      s_wstrb   = own_wstrb;
      own_rdy   = own_valid && (s_ready || tmo_expire);
      own_rdata = tmo_expire ? TIMEOUT_RDATA : s_rdata;
      if (sel1) begin
        m1_ready = own_rdy;
        m1_rdata = own_rdata;
      end else begin
        m0_ready = own_rdy;
        m0_rdata = own_rdata;
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic              bus_err_q;
  logic [ADDR_W-1:0] err_addr_q;

  bus_arb_timeout #(
    .MAX_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (!owning),
    .en_i     (owning && own_valid && !s_ready),
    .expire_o (tmo_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      bus_err_q <= tmo_expire;
      if (tmo_expire) begin
        err_addr_q <= own_addr;
      end
    end
  end

  assign bus_err  = bus_err_q;
  assign err_addr = err_addr_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo_expire         = 1'b0;
  assign bus_err            = 1'b0;
  assign err_addr           = '0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - checks RR and fixed-priority arbiters against a transaction-level model
module tb_bus_arbiter;

  localparam int unsigned TMO  = 8;
  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        m0_valid, m1_valid, s_ready;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;

  logic        sv[2], m0r[2], m1r[2], berr[2];
  logic [31:0] sa[2], sw[2], m0rd[2], m1rd[2], eaddr[2];
  logic [3:0]  sst[2];
  logic [1:0]  gr[2];

  int          own_m[2], last_m[2], stall_m[2];
  logic        berr_m[2];
  logic [31:0] eaddr_m[2];

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] rr_seq[6] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
  logic [1:0] fx_seq[6] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(TMO)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0r[0]), .m0_rdata(m0rd[0]),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1r[0]), .m1_rdata(m1rd[0]),
    .s_valid(sv[0]), .s_addr(sa[0]), .s_wdata(sw[0]), .s_wstrb(sst[0]),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(gr[0]), .bus_err(berr[0]), .err_addr(eaddr[0])
  );

  bus_arbiter #(.ARB_MODE(1), .TIMEOUT_CYCLES(TMO)) u_fx (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0r[1]), .m0_rdata(m0rd[1]),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1r[1]), .m1_rdata(m1rd[1]),
    .s_valid(sv[1]), .s_addr(sa[1]), .s_wdata(sw[1]), .s_wstrb(sst[1]),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(gr[1]), .bus_err(berr[1]), .err_addr(eaddr[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    own_m[d]   = -1;
    last_m[d]  = 1;
    stall_m[d] = 0;
    berr_m[d]  = 1'b0;
    eaddr_m[d] = 32'h0;
  endtask

  // d selects the model: 0 = round-robin, 1 = fixed priority. own = -1 means nobody holds the bus.
  task automatic model_dut(input int d);
    int          o;
    logic        v, ex, ev, er0, er1;
    logic [31:0] a, wd, ea, ewd, erd0, erd1;
    logic [3:0]  st, est;
    logic [1:0]  eg;
    o  = own_m[d];
    v  = 1'b0; ex = 1'b0; ev = 1'b0; er0 = 1'b0; er1 = 1'b0;
    a  = 32'h0; wd = 32'h0; st = 4'h0;
    ea = 32'h0; ewd = 32'h0; est = 4'h0; erd0 = 32'h0; erd1 = 32'h0; eg = 2'b00;
    if (o >= 0) begin
      v   = (o == 1) ? m1_valid : m0_valid;
      a   = (o == 1) ? m1_addr  : m0_addr;
      wd  = (o == 1) ? m1_wdata : m0_wdata;
      st  = (o == 1) ? m1_wstrb : m0_wstrb;
      ex  = TMO_ON && v && !s_ready && (stall_m[d] + 1 == int'(TMO));
      eg  = (o == 1) ? 2'b10 : 2'b01;
      ev  = v && !ex;
      ea  = a; ewd = wd; est = st;
      if (o == 1) begin
        er1  = v && (s_ready || ex);
        erd1 = ex ? DEAD : s_rdata;
      end else begin
        er0  = v && (s_ready || ex);
        erd0 = ex ? DEAD : s_rdata;
      end
    end
    chk($sformatf("d%0d s_valid", d),  32'(sv[d]),   32'(ev));
    chk($sformatf("d%0d s_addr", d),   sa[d],        ea);
    chk($sformatf("d%0d s_wdata", d),  sw[d],        ewd);
    chk($sformatf("d%0d s_wstrb", d),  32'(sst[d]),  32'(est));
    chk($sformatf("d%0d m0_ready", d), 32'(m0r[d]),  32'(er0));
    chk($sformatf("d%0d m0_rdata", d), m0rd[d],      erd0);
    chk($sformatf("d%0d m1_ready", d), 32'(m1r[d]),  32'(er1));
    chk($sformatf("d%0d m1_rdata", d), m1rd[d],      erd1);
    chk($sformatf("d%0d grant", d),    32'(gr[d]),   32'(eg));
    chk($sformatf("d%0d bus_err", d),  32'(berr[d]), 32'(berr_m[d]));
    chk($sformatf("d%0d err_addr", d), eaddr[d],     eaddr_m[d]);
    if (!reset_n) begin
      model_reset(d);
    end else begin
      berr_m[d] = ex;
      if (ex) eaddr_m[d] = a;
      if (o < 0) begin
        stall_m[d] = 0;
        if (m0_valid && m1_valid) own_m[d] = (d == 1 || last_m[d] == 1) ? 0 : 1;
        else if (m0_valid)        own_m[d] = 0;
        else if (m1_valid)        own_m[d] = 1;
      end else if (!v) begin
        own_m[d] = -1;
      end else if (s_ready || ex) begin
        own_m[d]  = -1;
        last_m[d] = o;
      end else begin
        stall_m[d]++;
      end
    end
  endtask

  task automatic adv();
    for (int d = 0; d < 2; d++) model_dut(d);
    @(negedge clk);
  endtask

  initial begin
    reset_n  = 1'b0;
    m0_valid = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    m1_valid = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    s_ready  = 1'b0; s_rdata = 32'h0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) model_reset(d);

    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst grant d%0d", d),   32'(gr[d]),   32'h0);
      chk($sformatf("rst s_valid d%0d", d), 32'(sv[d]),   32'h0);
      chk($sformatf("rst bus_err d%0d", d), 32'(berr[d]), 32'h0);
    end
    adv();
    reset_n = 1'b1;

    // Single-master read
    m0_valid = 1'b1; m0_addr = 32'h0002_0004; m0_wstrb = 4'h0; #1;
    chk("rd idle s_valid", 32'(sv[0]), 32'h0);
    adv();
    s_ready = 1'b1; s_rdata = 32'h1234_5678; #1;
    chk("rd s_valid", 32'(sv[0]), 32'h1);
    chk("rd s_addr", sa[0], 32'h0002_0004);
    chk("rd m0_ready", 32'(m0r[0]), 32'h1);
    chk("rd m0_rdata", m0rd[0], 32'h1234_5678);
    adv();
    m0_valid = 1'b0; s_ready = 1'b0; #1;
    chk("rd grant after", 32'(gr[0]), 32'h0);
    adv();

    // Tie from reset: RR alternates, fixed priority always picks m0
    reset_n = 1'b0; #1; adv();
    reset_n = 1'b1; m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
    m1_addr = 32'h0000_1000;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("tie rr grant %0d", i), 32'(gr[0]), 32'(rr_seq[i]));
      chk($sformatf("tie fx grant %0d", i), 32'(gr[1]), 32'(fx_seq[i]));
      chk($sformatf("tie fx m1_ready %0d", i), 32'(m1r[1]), 32'h0);
      adv();
    end
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
    repeat (2) begin #1; adv(); end

    // m1 write routing
    m1_valid = 1'b1; m1_addr = 32'h8000_0000; m1_wdata = 32'h0000_003F; m1_wstrb = 4'b0001;
    #1; adv();
    #1;
    chk("wr s_addr", sa[0], 32'h8000_0000);
    chk("wr s_wdata", sw[0], 32'h0000_003F);
    chk("wr s_wstrb", 32'(sst[0]), 32'h1);
    chk("wr m0_ready", 32'(m0r[0]), 32'h0);
    adv();
    s_ready = 1'b1; #1;
    chk("wr m1_ready", 32'(m1r[0]), 32'h1);
    chk("wr m0_ready end", 32'(m0r[0]), 32'h0);
    adv();
    m1_valid = 1'b0; s_ready = 1'b0; #1; adv();

`ifdef BUS_ARB_TIMEOUT_EN
    m0_valid = 1'b1; m0_addr = 32'h9000_0000; m0_wstrb = 4'h0; #1; adv();
    for (int i = 1; i <= int'(TMO); i++) begin
      #1;
      if (i < int'(TMO)) begin
        chk($sformatf("tmo wait m0_ready %0d", i), 32'(m0r[0]), 32'h0);
      end else begin
        chk("tmo m0_ready", 32'(m0r[0]), 32'h1);
        chk("tmo m0_rdata", m0rd[0], DEAD);
        chk("tmo s_valid", 32'(sv[0]), 32'h0);
      end
      adv();
    end
    m0_valid = 1'b0; #1;
    chk("tmo bus_err", 32'(berr[0]), 32'h1);
    chk("tmo err_addr", eaddr[0], 32'h9000_0000);
    adv();
    #1; chk("tmo bus_err pulse", 32'(berr[0]), 32'h0); adv();
    m0_valid = 1'b1; s_rdata = 32'hCAFE_0008; #1; adv();
    for (int i = 1; i <= int'(TMO); i++) begin
      s_ready = (i == int'(TMO)); #1;
      if (i == int'(TMO)) chk("late m0_rdata", m0rd[0], 32'hCAFE_0008);
      adv();
    end
    m0_valid = 1'b0; s_ready = 1'b0; #1;
    chk("late bus_err", 32'(berr[0]), 32'h0);
    adv();
`endif

    // m0 completes so reset has to restore last_owner for the tie below
    m0_valid = 1'b1; m0_addr = 32'h0000_0040; s_ready = 1'b1;
    repeat (2) begin #1; adv(); end
    m0_valid = 1'b0; s_ready = 1'b0; #1; adv();

    // Reset while m1 owns the bus
    m1_valid = 1'b1; m1_addr = 32'h0000_2000; #1; adv();
    #1; chk("rstmid grant", 32'(gr[0]), 32'h2); adv();
    reset_n = 1'b0; m0_valid = 1'b1; #1;
    chk("rstmid s_valid before", 32'(sv[0]), 32'h1);
    adv();
    #1;
    chk("rstmid s_valid", 32'(sv[0]), 32'h0);
    chk("rstmid grant0", 32'(gr[0]), 32'h0);
    adv();
    reset_n = 1'b1; #1; adv();
    #1; chk("rstmid tie winner", 32'(gr[0]), 32'h1); adv();
    m0_valid = 1'b0; m1_valid = 1'b0; #1; adv();

    // Randomized traffic
    repeat (600) begin
      reset_n  = ($urandom_range(0, 63) != 0);
      m0_valid = ($urandom_range(0, 3) != 0);
      m1_valid = ($urandom_range(0, 3) != 0);
      m0_addr  = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom);
      m1_addr  = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom);
      s_ready  = ($urandom_range(0, 2) == 0);
      s_rdata  = $urandom;
      #1; adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
